// File: rtl/fpu_issuer_if.sv
// fpu_issuer_if
// Bundles the exec-stage request bus, the FPU order/result handshake and the
// writeback port of the FP issuer into one interface.
//   master : the environment side (exec stage + FPU), drives requests, flush,
//            FPU accepted/done and result.
//   slave  : the issuer itself.
// Signals:
//   req, req_ready, req_func3, req_func7, req_a, req_b, req_tag, flush
//   order, accepted, done, func3, func7, rs1, rs2, rd
//   wb_valid, wb_tag, wb_data, err
interface fpu_issuer_if;
  logic        req;
  logic        req_ready;
  logic [2:0]  req_func3;
  logic [6:0]  req_func7;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_tag;
  logic        flush;
  logic        order;
  logic        accepted;
  logic        done;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] rd;
  logic        wb_valid;
  logic [4:0]  wb_tag;
  logic [31:0] wb_data;
  logic        err;

  modport master (
    output req, req_func3, req_func7, req_a, req_b, req_tag, flush,
    output accepted, done, rd,
    input  req_ready, order, func3, func7, rs1, rs2,
    input  wb_valid, wb_tag, wb_data, err
  );

  modport slave (
    input  req, req_func3, req_func7, req_a, req_b, req_tag, flush,
    input  accepted, done, rd,
    output req_ready, order, func3, func7, rs1, rs2,
    output wb_valid, wb_tag, wb_data, err
  );
endinterface

// File: rtl/fpu_issuer.sv
// fpu_issuer
// Hands one floating-point operation at a time from the exec stage to an
// external FPU and writes the result back. The op is latched on acceptance,
// presented to the FPU with `order` until the FPU accepts it, and the result
// (arriving the cycle after `done`) is strobed out on wb_valid. A pipeline
// flush discards the op; an op that exceeds TIMEOUT cycles is abandoned with
// a zero writeback and the sticky `err` flag set.
// Ports:
//   clk  : clock, rising edge
//   rstn : synchronous active-low reset
//   bus  : fpu_issuer_if.slave (request, FPU handshake, writeback, err)
// Parameter:
//   TIMEOUT : max cycles spent in ISSUE/WAIT before the op is abandoned
module fpu_issuer #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rstn,
  fpu_issuer_if.slave  bus
);

  // At least 8 bits, wider only if TIMEOUT needs it.
  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_t;

  state_t      state_reg;
  logic        order_reg;
  logic        discard_reg;
  logic        timed_out_reg;
  logic        err_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]  func3_reg;
  logic [6:0]  func7_reg;
  logic [31:0] rs1_reg;
  logic [31:0] rs2_reg;
  logic [4:0]  tag_reg;
  logic [31:0] wb_data_reg;

  logic        finish_now;
  logic        cnt_hit;
  logic [31:0] result_data;
  logic        wb_fire;

  // In ISSUE the op only completes if the FPU accepts and finishes together;
  // in WAIT any done completes it.
  assign finish_now = (state_reg == ISSUE) ? (bus.accepted && bus.done) : bus.done;

  // True on the TIMEOUT-th cycle spent in ISSUE/WAIT (counter starts at 0).
  assign cnt_hit = ({1'b0, cnt_reg} + (CW + 1)'(1)) >= (CW + 1)'(TIMEOUT);

  // rd is only valid in the cycle after done, so it is forwarded directly
  // while in RESULT; an abandoned op writes back zero.
  assign result_data = timed_out_reg ? 32'd0 : bus.rd;

  // A flush arriving in the RESULT cycle itself must still squash the strobe.
  assign wb_fire = rstn && (state_reg == RESULT) && !discard_reg && !bus.flush;

  assign bus.req_ready = rstn && (state_reg == IDLE);
  assign bus.order     = order_reg;
  assign bus.func3     = func3_reg;
  assign bus.func7     = func7_reg;
  assign bus.rs1       = rs1_reg;
  assign bus.rs2       = rs2_reg;
  assign bus.wb_valid  = wb_fire;
  assign bus.wb_tag    = tag_reg;
  assign bus.wb_data   = (state_reg == RESULT) ? result_data : wb_data_reg;
  assign bus.err       = err_reg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      order_reg     <= 1'b0;
      discard_reg   <= 1'b0;
      timed_out_reg <= 1'b0;
      err_reg       <= 1'b0;
      cnt_reg       <= '0;
      func3_reg     <= '0;
      func7_reg     <= '0;
      rs1_reg       <= '0;
      rs2_reg       <= '0;
      tag_reg       <= '0;
      wb_data_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Stray done pulses here (late completion after a timeout) are ignored.
          if (bus.req) begin
            func3_reg     <= bus.req_func3;
            func7_reg     <= bus.req_func7;
            rs1_reg       <= bus.req_a;
            rs2_reg       <= bus.req_b;
            tag_reg       <= bus.req_tag;
            discard_reg   <= 1'b0;
            timed_out_reg <= 1'b0;
            cnt_reg       <= '0;
            order_reg     <= 1'b1;
            state_reg     <= ISSUE;
          end
        end

        ISSUE, WAIT: begin
          if (cnt_reg != {CW{1'b1}}) begin
            cnt_reg <= cnt_reg + CW'(1);
          end
          if (state_reg == ISSUE && !bus.accepted && bus.flush) begin
            // FPU never saw the op, so it can simply be dropped.
            order_reg <= 1'b0;
            state_reg <= IDLE;
          end else begin
            // Once the FPU owns the op it cannot be aborted; remember the
            // flush and swallow the result instead.
            if (state_reg == WAIT || bus.accepted) begin
              discard_reg <= discard_reg | bus.flush;
            end
            if (finish_now) begin
              order_reg <= 1'b0;
              state_reg <= RESULT;
            end else if (cnt_hit) begin
              order_reg     <= 1'b0;
              timed_out_reg <= 1'b1;
              err_reg       <= 1'b1;
              state_reg     <= RESULT;
            end else if (state_reg == ISSUE && bus.accepted) begin
              order_reg <= 1'b0;
              state_reg <= WAIT;
            end
          end
        end

        RESULT: begin
          if (!discard_reg && !bus.flush) begin
            wb_data_reg <= result_data;
          end
          state_reg <= IDLE;
        end

        default: begin
          order_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fpu_issuer.md
FPU_ISSUER -- requirements
Module: fpu_issuer

Interface
REQ-001 Parameter: TIMEOUT, default 64, max cycles from order assertion to done before abort.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rstn  in  1  reset, synchronous, active-low.
REQ-004 req  in  1  exec stage requests an FP operation; sampled only when req_ready=1.
REQ-005 req_ready  out  1  issuer idle, can take req this cycle.
REQ-006 req_func3 / req_func7  in  3 / 7  operation codes.
REQ-007 req_a / req_b  in  32 / 32  operands.
REQ-008 req_tag  in  5  destination register index.
REQ-009 flush  in  1  discard in-flight op (pipeline squash).
REQ-010 order  out  1  request to FPU.
REQ-011 accepted / done  in  1 / 1  FPU handshake.
REQ-012 func3 / func7  out  3 / 7  registered codes to FPU.
REQ-013 rs1 / rs2  out  32 / 32  registered operands to FPU.
REQ-014 rd  in  32  FPU result; valid the cycle after done=1, held until next done.
REQ-015 wb_valid  out  1  one-cycle writeback strobe.
REQ-016 wb_tag / wb_data  out  5 / 32  writeback index and value.
REQ-017 err  out  1  sticky timeout flag.

Function
REQ-018 States: IDLE, ISSUE, WAIT, RESULT; req_ready = (state==IDLE).
REQ-019 IDLE & req: latch func3, func7, rs1, rs2, tag; clear discard flag and timeout counter; -> ISSUE.
REQ-020 ISSUE: order=1; func3/func7/rs1/rs2 stable; accepted & done -> RESULT; accepted & ~done -> WAIT; ~accepted -> stay.
REQ-021 order SHALL be 0 in every state except ISSUE; never two accepted ops outstanding.
REQ-022 WAIT: done -> RESULT; else stay.
REQ-023 RESULT: wb_data <= rd, wb_tag <= latched tag; wb_valid=1 for exactly this cycle unless discard set; -> IDLE.
REQ-024 Minimum latency (FPU accepts and finishes in same cycle): req at T, order at T+1, wb_valid at T+2.
REQ-025 Outputs func3/func7/rs1/rs2 hold last issued values outside ISSUE.
REQ-026 flush in ISSUE with accepted=0: -> IDLE, order low next cycle, no writeback.
REQ-027 flush in ISSUE with accepted=1, or in WAIT: set discard; continue to wait for done (FPU cannot abort); RESULT suppresses wb_valid.
REQ-028 flush in RESULT: suppress wb_valid this cycle; -> IDLE.
REQ-029 flush in IDLE: no effect; same-cycle req still accepted.
REQ-030 Timeout counter 8-bit min, increments each cycle in ISSUE/WAIT, saturates; reaching TIMEOUT without done: err<=1, wb_valid=1 with wb_data=0 unless discard, -> IDLE.
REQ-031 done while IDLE (stray after timeout) SHALL be ignored.
REQ-032 err sticky until reset; does not block further requests.

Reset
REQ-033 rstn=0 at clock edge: state IDLE; order, wb_valid, err, discard, counter, wb_tag, wb_data, func3, func7, rs1, rs2 all 0.
REQ-034 req_ready=0 while rstn=0; reset mid-operation abandons op with no writeback.

Verification
REQ-035 req fmv (FPU accepted&done same cycle as order, rd=0x3F800000 next cycle), tag 7 -> order at T+1, wb_valid at T+2, wb_tag=7, wb_data=0x3F800000.
REQ-036 FPU accepts at T+1, done at T+5, rd=0x40490FDB -> order high only T+1, wb_valid exactly once at T+6 with 0x40490FDB.
REQ-037 FPU withholds accepted 3 cycles -> order high 3+1 cycles, rs1/rs2 unchanged, single writeback.
REQ-038 flush during WAIT, done later -> no wb_valid, req_ready returns 1 cycle after RESULT.
REQ-039 TIMEOUT=8, FPU never done -> err=1 after 8 cycles, wb_data=0 strobe, later stray done ignored, next req completes normally.
REQ-040 rstn low during WAIT -> all outputs 0 next cycle, no writeback after release.
